// File: rtl/inv_cipher_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : inv_cipher_ctrl
//  Purpose  : Sequencing controller for AES-128 decryption around an external
//             inv_round datapath. It accepts a ciphertext block, applies the
//             initial AddRoundKey with the last round key, and then steps
//             inv_round through NR rounds: NR-1..1 are full rounds and round 0
//             is the final round without InvMixColumns. It returns the
//             plaintext on a valid/ready handshake.
//  Ports    :
//    clk            in   system clock, rising edge
//    n_rst          in   synchronous active-low reset
//    in_valid       in   ciphertext offered
//    in_ready       out  controller can accept a block
//    cipher_in      in   128-bit ciphertext, byte 0 at [127:120]
//    out_valid      out  plaintext available
//    out_ready      in   consumer accepts plaintext
//    plain_out      out  128-bit plaintext, same byte order as cipher_in
//    busy           out  a block is in flight
//    key_ready      in   key store is stable; gates acceptance only
//    key_idx        out  round-key index to the key store (0..NR)
//    round_key_in   in   round key for key_idx (combinational read)
//    round_data_out out  state presented to inv_round
//    round_mode     out  00 idle, 01 full round, 10 final round
//    round_data_in  in   inv_round result, valid ROUND_LAT clocks after issue
//  Revision : 1.0 - initial release
// ============================================================================
module inv_cipher_ctrl #(
    parameter int NR        = 10,
    parameter int ROUND_LAT = 1
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] cipher_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plain_out,
    output logic         busy,
    input  logic         key_ready,
    output logic [3:0]   key_idx,
    input  logic [127:0] round_key_in,
    output logic [127:0] round_data_out,
    output logic [1:0]   round_mode,
    input  logic [127:0] round_data_in
);

    localparam int               c_lcw      = $clog2(ROUND_LAT + 1);
    localparam logic [3:0]       c_nr       = 4'(NR);
    localparam logic [c_lcw-1:0] c_lat      = c_lcw'(ROUND_LAT);
    localparam logic [c_lcw-1:0] c_lcnt_one = c_lcw'(1);

    localparam logic [1:0] c_mode_idle  = 2'b00;
    localparam logic [1:0] c_mode_full  = 2'b01;
    localparam logic [1:0] c_mode_final = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } fsm_e;

    fsm_e             fsm_q,   fsm_d;
    logic [127:0]     state_q, state_d;
    logic [3:0]       rcnt_q,  rcnt_d;
    logic [c_lcw-1:0] lcnt_q,  lcnt_d;
    // Cleared by reset and set on the first edge with n_rst high, so that
    // in_ready stays low for as long as reset is held.
    logic             armed_q, armed_d;

    logic             w_accept;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            rcnt_q  <= '0;
            lcnt_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            lcnt_q  <= lcnt_d;
            armed_q <= armed_d;
        end
    end

    always_comb begin
        fsm_d          = fsm_q;
        state_d        = state_q;
        rcnt_d         = rcnt_q;
        lcnt_d         = lcnt_q;
        armed_d        = 1'b1;
        w_accept       = 1'b0;
        in_ready       = 1'b0;
        out_valid      = 1'b0;
        busy           = 1'b0;
        key_idx        = c_nr;
        round_mode     = c_mode_idle;
        round_data_out = state_q;
        plain_out      = state_q;

        case (fsm_q)
            ST_IDLE: begin
                in_ready = key_ready & armed_q;
                w_accept = in_valid & key_ready & armed_q;
                if (w_accept) begin
                    // Initial AddRoundKey with key NR is done here, not in inv_round.
                    state_d = cipher_in ^ round_key_in;
                    rcnt_d  = c_nr - 4'd1;
                    fsm_d   = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                busy       = 1'b1;
                key_idx    = rcnt_q;
                round_mode = (rcnt_q != 4'd0) ? c_mode_full : c_mode_final;
                lcnt_d     = c_lcnt_one;
                fsm_d      = ST_WAIT;
            end

            ST_WAIT: begin
                // Inputs to inv_round stay exactly as issued until its result lands.
                busy       = 1'b1;
                key_idx    = rcnt_q;
                round_mode = (rcnt_q != 4'd0) ? c_mode_full : c_mode_final;
                if (lcnt_q == c_lat) begin
                    state_d = round_data_in;
                    if (rcnt_q == 4'd0) begin
                        fsm_d = ST_DONE;
                    end else begin
                        rcnt_d = rcnt_q - 4'd1;
                        fsm_d  = ST_ISSUE;
                    end
                end else begin
                    lcnt_d = lcnt_q + c_lcnt_one;
                end
            end

            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    fsm_d = ST_IDLE;
                end
            end

            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/inv_cipher_ctrl.md
Name: inv_cipher_ctrl

Overview:
Sequencing controller for AES-128 decryption built around the inv_round datapath. It accepts a 128-bit ciphertext block with a valid/ready handshake and performs the initial AddRoundKey with key 10 itself. It then drives inv_round through NR rounds: rounds 9..1 are full rounds, and round 0 is the final round without InvMixColumns. It holds the working state between rounds, addresses the expanded-key store, and returns the plaintext on a valid/ready output handshake.

Parameters:
NR, 10, number of inverse rounds; the key index runs NR..0.
ROUND_LAT, 1, inv_round input-to-output latency in clocks (>=1).

Ports:
clk  in  1  system clock, rising edge.
n_rst  in  1  reset, synchronous, active-low.
in_valid  in  1  ciphertext offered.
in_ready  out  1  controller can accept a block.
cipher_in  in  128  ciphertext. Byte 0 is [127:120], which maps to inv_round data_in[0].
out_valid  out  1  plaintext available.
out_ready  in  1  consumer accepts plaintext.
plain_out  out  128  plaintext, same byte order as cipher_in.
busy  out  1  a block is in flight (ISSUE/WAIT/DONE).
key_ready  in  1  key expansion complete; the key store is stable.
key_idx  out  4  round-key index to the key store.
round_key_in  in  128  key word 0..3 at [127:96]..[31:0]; combinational read of key_idx.
round_data_out  out  128  state to inv_round data_in.
round_mode  out  2  00 idle, 01 full round, 10 final round (no InvMixColumns).
round_data_in  in  128  inv_round data_out.

Behaviour:
- Reset (n_rst low at a rising clk edge) takes effect at that edge:
  - FSM goes to IDLE; state register, round counter and latency counter all clear to 0.
  - in_ready=0 until the first edge with n_rst high; out_valid=0, busy=0, round_mode=00, key_idx=NR, plain_out=0.
- Reset has priority over all events, including in the middle of a round or in DONE. The block in flight is discarded with no output.
- IDLE:
  - key_idx=NR and in_ready=key_ready.
  - Accept on an edge with in_valid&&in_ready: state <= cipher_in ^ round_key_in, rcnt <= NR-1, go to ISSUE.
- ISSUE (1 cycle):
  - round_data_out=state, key_idx=rcnt.
  - round_mode=01 if rcnt!=0, else 10.
  - Go to WAIT with lcnt=1.
- WAIT (ROUND_LAT cycles):
  - round_data_out, key_idx and round_mode are held exactly as in ISSUE.
  - When lcnt==ROUND_LAT, state <= round_data_in at that edge.
  - If rcnt==0, go to DONE; else rcnt <= rcnt-1 and go to ISSUE.
  - Otherwise lcnt increments.
- DONE:
  - out_valid=1, plain_out=state; both are held stable while out_ready=0.
  - On an edge with out_ready=1, go to IDLE; out_valid falls the next cycle.
- Outside ISSUE/WAIT: round_mode=00 and round_data_out=state.
- Latency: accept in cycle 0 gives first out_valid in cycle NR*(ROUND_LAT+1)+1 (21 with defaults).
- One block at a time: in_ready=0 in ISSUE/WAIT/DONE. The next accept can occur in the cycle after the output handshake, so the minimum block period is NR*(ROUND_LAT+1)+2.
- in_valid while busy is ignored; the upstream block holds its data per the handshake.
- key_ready gates acceptance only. The key store must not change while busy=1; the controller does not monitor key_ready after acceptance.
- key_idx is always in range 0..NR; the round counter never wraps below 0.

Test Plan:
- FIPS-197 C.1 decrypt, 4 sub-checks:
  - Setup: key 000102030405060708090a0b0c0d0e0f expanded into the key-store model; cipher_in=69c4e0d86a7b0430d8cdb78070b4c55a; in_valid=1, out_ready=1.
  - Accept occurs in cycle 0.
  - out_valid=1 first in cycle 21, with plain_out=00112233445566778899aabbccddeeff.
  - busy falls in cycle 22.
- Sequence check: key_idx=10 at accept, then 9,8,...,0, each held 2 cycles; round_mode=01 for 9..1 and 10 for 0; round_data_out stable across each ISSUE+WAIT pair.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid and plain_out unchanged, in_ready=0. Raise out_ready -> in_ready=1 the next cycle.
- key_ready=0 with in_valid=1 for 4 cycles -> no accept, busy=0. Raise key_ready -> accept at the next edge.
- Reset in the WAIT of round 5 -> next cycle busy=0, out_valid=0, round_mode=00, key_idx=10. A following C.1 decrypt is correct.
- ROUND_LAT=3 instance, C.1 vector -> out_valid first in cycle 41 with the correct plaintext; each key_idx held 4 cycles.
